// File: rtl/ttt_pkg.sv
// ttt_pkg: shared TicTacToe encodings, the line-to-cell table, the referee FSM state type and
// small board helpers.
//   cell_t / CELL_*     : 2-bit cell encoding (11 is treated as empty)
//   winner_t / WIN_*    : round result encoding
//   LINE_CELLS          : cell indices of the eight winning lines, in scan order
//   ref_state_t / St*   : score_referee FSM state encoding
package ttt_pkg;

    typedef logic [1:0] cell_t;
    typedef logic [1:0] winner_t;
    typedef logic [2:0] ref_state_t;

    localparam cell_t CELL_EMPTY = 2'b00;
    localparam cell_t CELL_X     = 2'b01;
    localparam cell_t CELL_O     = 2'b10;

    localparam winner_t WIN_NONE = 2'b00;
    localparam winner_t WIN_X    = 2'b01;
    localparam winner_t WIN_O    = 2'b10;
    localparam winner_t WIN_DRAW = 2'b11;

    localparam int unsigned NUM_LINES = 8;
    localparam int unsigned NUM_CELLS = 9;

    // Rows, then columns, then the main and anti diagonals.
    localparam logic [3:0] LINE_CELLS [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    localparam ref_state_t StIdle  = 3'd0;
    localparam ref_state_t StScan  = 3'd1;
    localparam ref_state_t StAward = 3'd2;
    localparam ref_state_t StOver  = 3'd3;
    localparam ref_state_t StClear = 3'd4;

    function automatic cell_t cell_at(input logic [17:0] board, input logic [3:0] idx);
        return board[{idx, 1'b0} +: 2];
    endfunction

    // Only X and O count as occupied; the 11 pattern is an empty cell.
    function automatic logic cell_filled(input cell_t c);
        return (c == CELL_X) || (c == CELL_O);
    endfunction

    function automatic logic board_full(input logic [17:0] board);
        logic full;
        full = 1'b1;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (!cell_filled(cell_at(board, 4'(i)))) begin
                full = 1'b0;
            end
        end
        return full;
    endfunction

endpackage

// File: rtl/score_referee_if.sv
// score_referee_if: board/handshake/score-pulse bundle between the referee and the game datapath.
//   master : the referee (consumes board and requests, drives status and increment pulses)
//   slave  : the datapath side (game FSM, board register, Score_counter instances)
// Optional: DRAW_COUNT_EN adds inc_draw for a third Score_counter.
interface score_referee_if;
    import ttt_pkg::*;

    logic [17:0] board;
    logic        move_valid;
    logic        next_round;
    logic        busy;
    logic        inc_x;
    logic        inc_o;
    logic        round_over;
    winner_t     winner;
    logic [2:0]  win_line;
    logic        clear_board;
`ifdef DRAW_COUNT_EN
    logic        inc_draw;
`endif

    modport master (
        input  board, move_valid, next_round,
`ifdef DRAW_COUNT_EN
        output inc_draw,
`endif
        output busy, inc_x, inc_o, round_over, winner, win_line, clear_board
    );

    modport slave (
        output board, move_valid, next_round,
`ifdef DRAW_COUNT_EN
        input  inc_draw,
`endif
        input  busy, inc_x, inc_o, round_over, winner, win_line, clear_board
    );

endinterface

// File: rtl/line_checker.sv
// line_checker: combinational owner of one winning line.
//   board    : latched 3x3 board, cell i at [2i+1:2i]
//   line_idx : line to evaluate (0..7, order of LINE_CELLS)
//   owner    : CELL_X / CELL_O when all three cells hold that mark, else CELL_EMPTY
module line_checker
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  logic [2:0]  line_idx,
    output cell_t       owner
);

    cell_t a;
    cell_t b;
    cell_t c;

    always_comb begin
        a     = cell_at(board, LINE_CELLS[line_idx][0]);
        b     = cell_at(board, LINE_CELLS[line_idx][1]);
        c     = cell_at(board, LINE_CELLS[line_idx][2]);
        owner = CELL_EMPTY;
        if (cell_filled(a) && (a == b) && (b == c)) begin
            owner = a;
        end
    end

endmodule

// File: rtl/score_referee.sv
// score_referee: round referee. Latches the board on each committed move, scans the eight
// winning lines one per cycle, pulses the winner's score increment for PULSE_W cycles and then
// holds round_over until next_round, which clears the board and rearms the referee.
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   bus          : score_referee_if.master (board, move_valid, next_round in; busy, inc_x,
//                  inc_o, round_over, winner, win_line, clear_board out)
// Optional: DRAW_COUNT_EN also pulses bus.inc_draw on a draw.
module score_referee
    import ttt_pkg::*;
#(
    parameter int unsigned PULSE_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    score_referee_if.master bus
);

    ref_state_t  state_q, state_d;
    logic [17:0] board_q, board_d;
    logic [2:0]  line_idx_q, line_idx_d;
    logic [3:0]  pulse_cnt_q, pulse_cnt_d;
    winner_t     winner_q, winner_d;
    logic [2:0]  win_line_q, win_line_d;

    // Outputs are registered images of the next state so they carry no input-to-output path.
    logic busy_q;
    logic inc_x_q;
    logic inc_o_q;
    logic round_over_q;
    logic clear_board_q;
`ifdef DRAW_COUNT_EN
    logic inc_draw_q;
`endif

    cell_t owner;

    line_checker u_line_checker (
        .board    (board_q),
        .line_idx (line_idx_q),
        .owner    (owner)
    );

    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        line_idx_d  = line_idx_q;
        pulse_cnt_d = pulse_cnt_q;
        winner_d    = winner_q;
        win_line_d  = win_line_q;

        case (state_q)
            StIdle: begin
                if (bus.move_valid) begin
                    board_d    = bus.board;
                    line_idx_d = 3'd0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                // Lines are scanned in ascending order, so the lowest winning line decides
                // an illegal board that has both X and O lines.
                if (owner != CELL_EMPTY) begin
                    winner_d    = (owner == CELL_X) ? WIN_X : WIN_O;
                    win_line_d  = line_idx_q;
                    pulse_cnt_d = 4'd0;
                    state_d     = StAward;
                end else if (line_idx_q == 3'd7) begin
                    if (board_full(board_q)) begin
                        winner_d    = WIN_DRAW;
                        win_line_d  = 3'd0;
                        pulse_cnt_d = 4'd0;
                        state_d     = StAward;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    line_idx_d = line_idx_q + 3'd1;
                end
            end
            StAward: begin
                if (pulse_cnt_q == 4'(PULSE_W - 1)) begin
                    state_d = StOver;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 4'd1;
                end
            end
            StOver: begin
                if (bus.next_round) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                winner_d   = WIN_NONE;
                win_line_d = 3'd0;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            board_q       <= '0;
            line_idx_q    <= '0;
            pulse_cnt_q   <= '0;
            winner_q      <= WIN_NONE;
            win_line_q    <= '0;
            busy_q        <= 1'b0;
            inc_x_q       <= 1'b0;
            inc_o_q       <= 1'b0;
            round_over_q  <= 1'b0;
            clear_board_q <= 1'b0;
`ifdef DRAW_COUNT_EN
            inc_draw_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            board_q       <= board_d;
            line_idx_q    <= line_idx_d;
            pulse_cnt_q   <= pulse_cnt_d;
            winner_q      <= winner_d;
            win_line_q    <= win_line_d;
            busy_q        <= (state_d != StIdle);
            inc_x_q       <= (state_d == StAward) && (winner_d == WIN_X);
            inc_o_q       <= (state_d == StAward) && (winner_d == WIN_O);
            round_over_q  <= (state_d == StOver);
            clear_board_q <= (state_d == StClear);
`ifdef DRAW_COUNT_EN
            inc_draw_q    <= (state_d == StAward) && (winner_d == WIN_DRAW);
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.inc_x       = inc_x_q;
    assign bus.inc_o       = inc_o_q;
    assign bus.round_over  = round_over_q;
    assign bus.winner      = winner_q;
    assign bus.win_line    = win_line_q;
    assign bus.clear_board = clear_board_q;
`ifdef DRAW_COUNT_EN
    assign bus.inc_draw    = inc_draw_q;
`endif

endmodule

// File: tb/tb_score_referee.sv
// tb_score_referee: directed self-checking bench for score_referee with a scoreboard of
// expected round results built from an independent board model.
module tb_score_referee;

    localparam int PW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    score_referee_if bus ();

    score_referee #(
        .PULSE_W (PW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    typedef struct {
        logic [1:0] winner;
        logic [2:0] line;
        int         rise;
    } exp_t;

    exp_t sb[$];

    int lines [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    // Downstream X Score_counter model: counts rising edges of inc_x, cleared by reset.
    int   score_x;
    logic inc_x_d1;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score_x  <= 0;
            inc_x_d1 <= 1'b0;
        end else begin
            inc_x_d1 <= bus.inc_x;
            if (bus.inc_x && !inc_x_d1) score_x <= score_x + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] mk(input string s);
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) begin
            case (s[i])
                "X":     b[2*i +: 2] = 2'b01;
                "O":     b[2*i +: 2] = 2'b10;
                "#":     b[2*i +: 2] = 2'b11;
                default: b[2*i +: 2] = 2'b00;
            endcase
        end
        return b;
    endfunction

    function automatic void model(input logic [17:0] b, output logic [1:0] w,
                                  output logic [2:0] ln);
        logic       found;
        logic       full;
        logic [1:0] c0, c1, c2;
        w = 2'b00;
        ln = 3'd0;
        found = 1'b0;
        full = 1'b1;
        for (int l = 0; l < 8; l++) begin
            c0 = b[2*lines[l][0] +: 2];
            c1 = b[2*lines[l][1] +: 2];
            c2 = b[2*lines[l][2] +: 2];
            if (!found && (c0 == 2'b01 || c0 == 2'b10) && c0 == c1 && c1 == c2) begin
                found = 1'b1;
                w = c0;
                ln = 3'(l);
            end
        end
        for (int i = 0; i < 9; i++) begin
            if (!(b[2*i +: 2] == 2'b01 || b[2*i +: 2] == 2'b10)) full = 1'b0;
        end
        if (!found && full) w = 2'b11;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_incs"}, {bus.inc_x, bus.inc_o}, 0);
        check({tag, "_over"}, bus.round_over, 0);
        check({tag, "_result"}, {bus.winner, bus.win_line, bus.clear_board}, 0);
    endtask

    // Commits a move on the given board and watches the DUT until round_over or idle.
    task automatic run_round(input string tag, input string s, input bit disturb);
        exp_t e;
        logic [17:0] b;
        int nx, no, nd, rx, ro, both, busy_cycles, over_at, clr;
        b = mk(s);
        model(b, e.winner, e.line);
        e.rise = (e.winner == 2'b11) ? 9 : 2 + int'(e.line);
        sb.push_back(e);
        nx = 0; no = 0; nd = 0; rx = -1; ro = -1; both = 0; busy_cycles = 0;
        over_at = -1; clr = 0;
        bus.board = b;
        bus.move_valid = 1'b1;
        @(negedge clk);
        bus.move_valid = 1'b0;
        check({tag, "_busy_rise"}, bus.busy, 1);
        for (int n = 1; n <= 30; n++) begin
            if (bus.busy) busy_cycles++;
            if (bus.inc_x) begin nx++; if (rx < 0) rx = n; end
            if (bus.inc_o) begin no++; if (ro < 0) ro = n; end
            if (bus.inc_x && bus.inc_o) both++;
            if (bus.clear_board) clr++;
`ifdef DRAW_COUNT_EN
            if (bus.inc_draw) nd++;
`endif
            if (disturb && n == 3) begin
                bus.board = mk("XXX......");
                bus.move_valid = 1'b1;
                bus.next_round = 1'b1;
            end else begin
                bus.move_valid = 1'b0;
                bus.next_round = 1'b0;
            end
            if (bus.round_over) begin over_at = n; break; end
            if (!bus.busy) break;
            @(negedge clk);
        end
        bus.move_valid = 1'b0;
        bus.next_round = 1'b0;
        e = sb.pop_front();
        check({tag, "_winner"}, bus.winner, e.winner);
        check({tag, "_win_line"}, bus.win_line, e.line);
        check({tag, "_inc_x_len"}, nx, (e.winner == 2'b01) ? PW : 0);
        check({tag, "_inc_o_len"}, no, (e.winner == 2'b10) ? PW : 0);
        check({tag, "_inc_overlap"}, both, 0);
        check({tag, "_clear_board"}, clr, 0);
        if (e.winner == 2'b01) check({tag, "_inc_x_rise"}, rx, e.rise);
        if (e.winner == 2'b10) check({tag, "_inc_o_rise"}, ro, e.rise);
`ifdef DRAW_COUNT_EN
        check({tag, "_inc_draw_len"}, nd, (e.winner == 2'b11) ? PW : 0);
`endif
        if (e.winner == 2'b00) begin
            check({tag, "_scan_busy"}, busy_cycles, 8);
            check({tag, "_no_over"}, over_at, -1);
        end else begin
            check({tag, "_over_at"}, over_at, e.rise + PW);
        end
    endtask

    task automatic do_next_round(input string tag);
        bus.next_round = 1'b1;
        @(negedge clk);
        bus.next_round = 1'b0;
        check({tag, "_clear_pulse"}, {bus.clear_board, bus.round_over, bus.busy}, 3'b101);
        @(negedge clk);
        check_idle_outputs({tag, "_after_clear"});
    endtask

    initial begin
        bus.board = '0;
        bus.move_valid = 1'b0;
        bus.next_round = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
`ifdef DRAW_COUNT_EN
        check("reset_inc_draw", bus.inc_draw, 0);
`endif
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        run_round("x_row0", "XXX......", 1'b0);
        do_next_round("x_row0_nr");

        run_round("o_anti", "X.O.O.OX.", 1'b0);
        do_next_round("o_anti_nr");

        run_round("draw", "XOXXOOOXX", 1'b0);
        do_next_round("draw_nr");

        run_round("partial", "XO.......", 1'b0);
        check_idle_outputs("partial_end");

        run_round("dont_care", "###......", 1'b0);
        check_idle_outputs("dont_care_end");

        run_round("o_col_disturb", "XO..OX.OX", 1'b1);
        do_next_round("o_col_nr");

        run_round("illegal", "XXXOOO...", 1'b0);
        do_next_round("illegal_nr");

        // Reset during the second AWARD cycle of an X row-0 win.
        bus.board = mk("XXX......");
        bus.move_valid = 1'b1;
        @(negedge clk);
        bus.move_valid = 1'b0;
        @(negedge clk);
        check("abort_inc_x_up", bus.inc_x, 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("abort_reset");
        check("abort_score_cleared", score_x, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("abort_released");

        run_round("rescore", "XXX......", 1'b0);
        do_next_round("rescore_nr");
        check("rescore_counter", score_x, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/score_referee.md
# score_referee

Round referee for the TicTacToe datapath. It samples the 3x3 board after each committed move and scans the eight winning lines, one per cycle. It then drives the increment inputs of the per-player Score_counter instances and holds the game in a round-over state until the next round is requested. It is the producer side of the score increment/reset interface: Score_counter consumes the pulses that this block generates.

## Interface
- PULSE_W, 4: cycles each increment pulse is held high (1..15); gives Score_counter a clean, glitch-free edge
- clk  input  1  system clock, rising edge
- reset_n  input  1  reset; one clock; asynchronous, active-low
- board  input  18  cell i at bits [2i+1:2i]; 00 empty, 01 X, 10 O, 11 treated as empty; cells 0..8 row-major
- move_valid  input  1  one-cycle pulse: board holds a newly committed move
- next_round  input  1  one-cycle pulse: start a new round (honoured only in OVER)
- busy  output  1  high in every state except IDLE
- inc_x  output  1  increment pulse to the X Score_counter
- inc_o  output  1  increment pulse to the O Score_counter
- round_over  output  1  level, high in OVER
- winner  output  2  00 none, 01 X, 10 O, 11 draw; valid while round_over=1
- win_line  output  3  index of the winning line; 0 on a draw
- clear_board  output  1  one-cycle pulse asking the board register to clear

## Operation
- Line order:
  - 0..2 are rows {0,1,2}, {3,4,5}, {6,7,8}.
  - 3..5 are columns {0,3,6}, {1,4,7}, {2,5,8}.
  - 6 is diagonal {0,4,8}; 7 is diagonal {2,4,6}.
- A line wins when all three of its cells are equal and equal to 01 or 10.
- FSM states: IDLE, SCAN, AWARD, OVER, CLEAR.
- IDLE, on move_valid:
  - Latch board into board_q.
  - Set line_idx to 0.
  - Go to SCAN.
- SCAN evaluates line line_idx each cycle:
  - If the line wins: record winner and win_line, then go to AWARD.
  - Otherwise, if line_idx=7: go to AWARD as a draw when all nine cells are non-empty; else go to IDLE.
  - Otherwise: increment line_idx.
- AWARD holds the selected increment high for exactly PULSE_W cycles, then goes to OVER:
  - inc_x for an X win, inc_o for an O win.
  - Neither on a draw, unless DRAW_COUNT_EN is defined (see Configuration).
- OVER holds round_over=1. On next_round, go to CLEAR.
- CLEAR asserts clear_board for one cycle, zeroes winner and win_line, and returns to IDLE.
- move_valid is ignored in every state except IDLE. next_round is ignored in every state except OVER.
- If board_q is illegal with both X and O winning lines, the lowest-indexed winning line decides the result.
- inc_x and inc_o are never high together. Increment outputs come straight from registers, with no combinational path from inputs.

## Timing
- Reset value of every output is 0. After reset the FSM is in IDLE, line_idx=0 and board_q=0.
- Reset asserted mid-round (including during AWARD) drops any increment pulse immediately. No partial score is re-issued after reset.
- move_valid is sampled on edge T, so busy=1 from T+1.
- A winning line k is detected in SCAN cycle k. The increment rises at T+2+k and stays high PULSE_W cycles.
- round_over rises on the cycle after the pulse ends.
- Non-winning, non-full board: busy is high for 8 cycles, then the FSM is back in IDLE. No outputs change apart from busy.
- next_round sampled at edge N: clear_board=1 in cycle N+1, and busy=0 and IDLE from N+2.
- A move_valid arriving while busy=1 is dropped. The upstream game FSM must not commit moves while busy.

## Configuration
- DRAW_COUNT_EN: when defined, adds output port inc_draw (1 bit, reset 0). A draw pulses inc_draw for PULSE_W cycles in AWARD, to feed a third Score_counter.
- When not defined: the port is absent. A draw passes through AWARD for PULSE_W cycles with no output pulse, then enters OVER with winner=11.

## Structure
- Shared package ttt_pkg:
  - cell encoding constants CELL_EMPTY, CELL_X, CELL_O
  - winner encoding WIN_NONE, WIN_X, WIN_O, WIN_DRAW
  - the 8x3 line-to-cell index table LINE_CELLS
  - FSM state typedef ref_state_t
- One natural sub-module, line_checker: combinational logic that takes board_q and a line index and returns a 2-bit line owner (00 when there is no win). Instantiated once and reused every SCAN cycle.

## Test plan
- X wins top row: board=cells 0,1,2=01, others empty, then move_valid -> inc_x high for 4 cycles starting 2 cycles after move_valid; winner=01, win_line=0; inc_o stays 0.
- O wins anti-diagonal: cells 2,4,6=10, plus two scattered X cells -> inc_o pulses 4 cycles starting 9 cycles after move_valid (k=7); win_line=7, round_over=1 afterwards.
- Full board with no line, e.g. X,O,X,X,O,O,O,X,X -> no inc_x or inc_o; winner=11 and round_over=1. With DRAW_COUNT_EN, inc_draw pulses for 4 cycles.
- Partial board with no win -> busy high for 8 cycles, then IDLE; every output stays 0.
- move_valid re-pulsed during SCAN, and next_round pulsed during SCAN, are both ignored. In OVER, next_round -> one clear_board pulse, then IDLE with winner=00.
- reset_n asserted during the 2nd AWARD cycle -> inc_x drops to 0 immediately and all outputs stay 0. A fresh move_valid after release scores normally, so the downstream counter ends at exactly +1.
